fetch_redirect_ctrl: RTL and testbench
======================================

// Module: fetch_redirect_ctrl
// PURPOSE
//  Sequencer for the fetch PC register. Decides each cycle whether the PC holds, advances by 4 or loads a redirect target.
//  Arbitrates the three redirect sources (trap, branch, jump) and generates the IF/ID squash window.
//  Provides debug halt/resume. Sits between EX/WB redirect sources and the PC register's advance/redirect/target inputs.
// PARAMETERS
//  XLEN          32            address width
//  RESET_PC      32'h0000_01CC boot fetch address, issued as first redirect after reset
//  FLUSH_CYCLES  2             squash window length after any redirect (1..15)
//  CNT_W         16            width of saturating redirect counter
// PORTS
//  clk_i            in   1      clock, all state updates on posedge
//  reset_i          in   1      synchronous, active-high reset
//  enable_i         in   1      global run enable; 0 freezes all state
//  if_ready_i       in   1      fetch stage can accept a new PC
//  trap_req_i       in   1      trap/exception redirect request
//  trap_vec_i       in   XLEN   trap target
//  branch_req_i     in   1      taken-branch redirect request
//  branch_target_i  in   XLEN   branch target
//  jump_req_i       in   1      jump redirect request
//  jump_target_i    in   XLEN   jump target
//  halt_req_i       in   1      debug halt request (level)
//  resume_req_i     in   1      debug resume request (pulse)
//  resume_pc_i      in   XLEN   PC to resume at
//  pc_advance_o     out  1      PC <= PC+4 this cycle
//  pc_redirect_o    out  1      PC <= redirect_pc_o this cycle
//  redirect_pc_o    out  XLEN   redirect target (valid with pc_redirect_o)
//  redirect_src_o   out  2      0 none/boot/resume, 1 jump, 2 branch, 3 trap
//  flush_o          out  1      squash IF/ID contents
//  halted_o         out  1      core fetch halted
//  redirect_cnt_o   out  CNT_W  saturating count of redirects taken
// BEHAVIOUR
//  - States: BOOT, RUN, FLUSH, HALTED. Reset (sync, any state, mid-flush incl.) -> BOOT, flush ctr 0, halt_pend 0,
//    redirect_cnt 0; all outputs 0 except redirect_pc_o = 0.
//  - enable_i=0: every output 0 (redirect_cnt_o holds), state/counters/halt_pend frozen, requests ignored.
//  - BOOT (enable_i=1): pc_redirect_o=1, redirect_pc_o=RESET_PC, src 0 -> RUN next cycle; no flush, not counted.
//  - Arbitration (combinational, same cycle): trap > branch > jump; losers dropped, never queued.
//    Winning redirect is issued the same cycle regardless of if_ready_i (zero latency).
//  - RUN: winner -> pc_redirect_o=1, target/src driven, redirect_cnt++ (saturate at all-ones),
//    flush ctr <= FLUSH_CYCLES, -> FLUSH. No winner -> pc_advance_o = if_ready_i.
//  - FLUSH: flush_o=1 every cycle; ctr decrements; ctr reaching 1 -> RUN next cycle (flush_o high exactly FLUSH_CYCLES cycles,
//    starting the cycle after the redirect). Branch/jump ignored (squashed path). Trap accepted: redirect issued,
//    counted, ctr reloads to FLUSH_CYCLES. pc_advance_o = if_ready_i & ~pc_redirect_o.
//  - Halt: halt_req_i in RUN/FLUSH sets halt_pend. halt_pend & no redirect this cycle -> HALTED next cycle
//    (pending flush abandoned, flush_o low). Redirect and halt in same cycle: redirect taken, halt honoured next cycle.
//  - HALTED: halted_o=1, pc_advance_o=0; trap/branch/jump ignored. resume_req_i -> pc_redirect_o=1,
//    redirect_pc_o=resume_pc_i, src 0, counted, halt_pend cleared, -> FLUSH. resume beats a simultaneous halt_req_i.
//    resume_req_i outside HALTED ignored.
//  - pc_advance_o and pc_redirect_o never both 1. All outputs combinational from state+inputs except halted_o, flush_o (registered).
// STRUCTURE
//  - Package fetch_ctrl_pkg: state enum, redirect_src codes (SRC_NONE/JUMP/BRANCH/TRAP), RESET_PC default.
//  - Sub-module redirect_prio_arb: pure fixed-priority 3-way select -> {valid, src, target}; FSM + counters stay in top.
// TESTING
//  - Reset, enable_i=1 -> cycle 1 pc_redirect_o=1 to 0x1CC; then if_ready_i=1 gives pc_advance_o=1 every cycle.
//  - trap+branch+jump same cycle (0x100/0x200/0x300) -> redirect_pc_o=0x100, src=3, flush_o high 2 cycles, cnt=1.
//  - branch to 0x400, then jump during FLUSH -> jump ignored; trap at flush cycle 2 -> redirect, flush reloads to 2 cycles.
//  - halt_req_i with jump same cycle -> jump taken, HALTED 1 cycle later; resume_req_i, resume_pc_i=0x800 -> redirect 0x800, flush 2.
//  - enable_i=0 for 5 cycles mid-FLUSH -> outputs 0, ctr held; re-enable completes remaining flush cycles.
//  - reset_i mid-FLUSH and in HALTED -> BOOT next cycle, cnt 0; cnt forced to 0xFFFF saturates on further redirect.

Source files
------------

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch redirect sequencer.
package fetch_ctrl_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    // Redirect source codes reported on redirect_src_o.
    localparam logic [1:0] SRC_NONE   = 2'd0;
    localparam logic [1:0] SRC_JUMP   = 2'd1;
    localparam logic [1:0] SRC_BRANCH = 2'd2;
    localparam logic [1:0] SRC_TRAP   = 2'd3;

    // Boot fetch address.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_01CC;

    // Squash window counter width; holds up to 15 cycles.
    localparam int FLUSH_CTR_W = 4;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Redirect-source / PC-register bundle for the fetch redirect sequencer.
interface fetch_redirect_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             if_ready_i;
    logic             trap_req_i;
    logic [XLEN-1:0]  trap_vec_i;
    logic             branch_req_i;
    logic [XLEN-1:0]  branch_target_i;
    logic             jump_req_i;
    logic [XLEN-1:0]  jump_target_i;
    logic             halt_req_i;
    logic             resume_req_i;
    logic [XLEN-1:0]  resume_pc_i;
    logic             pc_advance_o;
    logic             pc_redirect_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic [1:0]       redirect_src_o;
    logic             flush_o;
    logic             halted_o;
    logic [CNT_W-1:0] redirect_cnt_o;

    // Pipeline side: drives requests, observes PC control.
    modport master (
        output if_ready_i, trap_req_i, trap_vec_i, branch_req_i, branch_target_i,
               jump_req_i, jump_target_i, halt_req_i, resume_req_i, resume_pc_i,
        input  pc_advance_o, pc_redirect_o, redirect_pc_o, redirect_src_o,
               flush_o, halted_o, redirect_cnt_o
    );

    // Sequencer side.
    modport slave (
        input  if_ready_i, trap_req_i, trap_vec_i, branch_req_i, branch_target_i,
               jump_req_i, jump_target_i, halt_req_i, resume_req_i, resume_pc_i,
        output pc_advance_o, pc_redirect_o, redirect_pc_o, redirect_src_o,
               flush_o, halted_o, redirect_cnt_o
    );

endinterface

// File: rtl/fetch_redirect_ctrl_redirect_prio_arb.sv
// Fixed-priority select among trap, branch and jump redirect requests.
module redirect_prio_arb
    import fetch_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            branch_req,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump_req,
    input  logic [XLEN-1:0] jump_target,
    output logic            valid,
    output logic [1:0]      src,
    output logic [XLEN-1:0] target
);

    // Trap beats branch beats jump; losing requests are simply dropped.
    always_comb begin
        valid  = 1'b1;
        src    = SRC_TRAP;
        target = trap_vec;
        if (trap_req) begin
            src    = SRC_TRAP;
            target = trap_vec;
        end else if (branch_req) begin
            src    = SRC_BRANCH;
            target = branch_target;
        end else if (jump_req) begin
            src    = SRC_JUMP;
            target = jump_target;
        end else begin
            valid  = 1'b0;
            src    = SRC_NONE;
            target = '0;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: boot redirect, redirect arbitration, squash window, debug halt/resume.
module fetch_redirect_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC     = XLEN'(DEFAULT_RESET_PC),
    parameter int              FLUSH_CYCLES = 2,
    parameter int              CNT_W        = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic enable_i,
    fetch_redirect_ctrl_if.slave bus
);

    localparam logic [FLUSH_CTR_W-1:0] FLUSH_LOAD = FLUSH_CTR_W'(FLUSH_CYCLES);

    fetch_state_e           state_q, state_d;
    logic [FLUSH_CTR_W-1:0] ctr_q, ctr_d;
    logic                   halt_pend_q, halt_pend_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   flush_q, halted_q;

    logic                   active;
    logic                   arb_trap, arb_branch, arb_jump;
    logic                   arb_valid;
    logic [1:0]             arb_src;
    logic [XLEN-1:0]        arb_target;

    logic                   pc_advance, pc_redirect;
    logic [XLEN-1:0]        redirect_pc;
    logic [1:0]             redirect_src;

    assign active = enable_i & ~reset_i;

    // Branch/jump only matter in RUN (FLUSH is on a squashed path); traps in RUN or FLUSH.
    assign arb_trap   = bus.trap_req_i   & ((state_q == ST_RUN) | (state_q == ST_FLUSH));
    assign arb_branch = bus.branch_req_i &  (state_q == ST_RUN);
    assign arb_jump   = bus.jump_req_i   &  (state_q == ST_RUN);

    redirect_prio_arb #(.XLEN(XLEN)) u_arb (
        .trap_req      (arb_trap),
        .trap_vec      (bus.trap_vec_i),
        .branch_req    (arb_branch),
        .branch_target (bus.branch_target_i),
        .jump_req      (arb_jump),
        .jump_target   (bus.jump_target_i),
        .valid         (arb_valid),
        .src           (arb_src),
        .target        (arb_target)
    );

    // State register plus counters; everything freezes while enable_i is low.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_BOOT;
            ctr_q       <= '0;
            halt_pend_q <= 1'b0;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else if (enable_i) begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            halt_pend_q <= halt_pend_d;
            cnt_q       <= cnt_d;
            flush_q     <= (state_d == ST_FLUSH);
            halted_q    <= (state_d == ST_HALTED);
        end
    end

    // Next-state, squash counter, pending halt and saturating redirect count.
    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        halt_pend_d = halt_pend_q;
        cnt_d       = cnt_q;
        if (((state_q == ST_RUN) || (state_q == ST_FLUSH)) && bus.halt_req_i)
            halt_pend_d = 1'b1;
        if (pc_redirect && (state_q != ST_BOOT) && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (arb_valid) begin
                    state_d = ST_FLUSH;
                    ctr_d   = FLUSH_LOAD;
                end else if (halt_pend_q) begin
                    state_d = ST_HALTED;
                    ctr_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (arb_valid) begin
                    ctr_d = FLUSH_LOAD;
                end else if (halt_pend_q) begin
                    // Halting abandons whatever is left of the squash window.
                    state_d = ST_HALTED;
                    ctr_d   = '0;
                end else if (ctr_q <= FLUSH_CTR_W'(1)) begin
                    state_d = ST_RUN;
                    ctr_d   = '0;
                end else begin
                    ctr_d = ctr_q - 1'b1;
                end
            end
            ST_HALTED: begin
                if (bus.resume_req_i) begin
                    state_d     = ST_FLUSH;
                    ctr_d       = FLUSH_LOAD;
                    halt_pend_d = 1'b0;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // PC control outputs, combinational from state and this cycle's requests.
    always_comb begin
        pc_advance   = 1'b0;
        pc_redirect  = 1'b0;
        redirect_pc  = '0;
        redirect_src = SRC_NONE;
        if (active) begin
            case (state_q)
                ST_BOOT: begin
                    pc_redirect = 1'b1;
                    redirect_pc = RESET_PC;
                end
                ST_RUN, ST_FLUSH: begin
                    if (arb_valid) begin
                        pc_redirect  = 1'b1;
                        redirect_pc  = arb_target;
                        redirect_src = arb_src;
                    end
                    pc_advance = bus.if_ready_i & ~arb_valid;
                end
                ST_HALTED: begin
                    if (bus.resume_req_i) begin
                        pc_redirect = 1'b1;
                        redirect_pc = bus.resume_pc_i;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc_advance_o   = pc_advance;
    assign bus.pc_redirect_o  = pc_redirect;
    assign bus.redirect_pc_o  = redirect_pc;
    assign bus.redirect_src_o = redirect_src;
    assign bus.flush_o        = flush_q & active;
    assign bus.halted_o       = halted_q & active;
    assign bus.redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios then random traffic vs a behavioural model.
module tb_fetch_redirect_ctrl;
    import fetch_ctrl_pkg::*;

    localparam int          XLEN    = 32;
    localparam int          FC      = 2;
    localparam int          CNT_W   = 16;
    localparam int          SMALL_W = 3;
    localparam logic [31:0] BOOT_PC = 32'h0000_01CC;

    // Control bits for the per-cycle stimulus word.
    localparam int RST = 1, EN = 2, RDY = 4, TR = 8, BR = 16, JR = 32, HR = 64, RS = 128;

    logic clk;
    logic reset;
    logic enable;
    int   n_chk;
    int   n_pass;

    // Reference model: counts rather than state codes.
    bit   m_boot;
    bit   m_halted;
    bit   m_pend;
    int   m_flush_left;
    int   m_cnt;

    fetch_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W))   bus ();
    fetch_redirect_ctrl_if #(.XLEN(XLEN), .CNT_W(SMALL_W)) bus_s ();

    fetch_redirect_ctrl #(.XLEN(XLEN), .RESET_PC(BOOT_PC), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk_i    (clk),
        .reset_i  (reset),
        .enable_i (enable),
        .bus      (bus)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation.
    fetch_redirect_ctrl #(.XLEN(XLEN), .RESET_PC(BOOT_PC), .FLUSH_CYCLES(FC), .CNT_W(SMALL_W)) dut_s (
        .clk_i    (clk),
        .reset_i  (reset),
        .enable_i (enable),
        .bus      (bus_s)
    );

    assign bus_s.if_ready_i      = bus.if_ready_i;
    assign bus_s.trap_req_i      = bus.trap_req_i;
    assign bus_s.trap_vec_i      = bus.trap_vec_i;
    assign bus_s.branch_req_i    = bus.branch_req_i;
    assign bus_s.branch_target_i = bus.branch_target_i;
    assign bus_s.jump_req_i      = bus.jump_req_i;
    assign bus_s.jump_target_i   = bus.jump_target_i;
    assign bus_s.halt_req_i      = bus.halt_req_i;
    assign bus_s.resume_req_i    = bus.resume_req_i;
    assign bus_s.resume_pc_i     = bus.resume_pc_i;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    endtask

    // One clock: drive, check outputs before the edge, then advance the model.
    task automatic cyc(input int ctl, input logic [31:0] tv, input logic [31:0] bt,
                       input logic [31:0] jt, input logic [31:0] rp);
        logic        rst, en, rdy, tr, br, jr, hr, rr;
        logic        e_adv, e_red, e_flush, e_halt;
        logic [31:0] e_pc;
        logic [1:0]  e_src;
        int          sat_big, sat_small;
        rst = (ctl & RST) != 0; en = (ctl & EN) != 0; rdy = (ctl & RDY) != 0;
        tr  = (ctl & TR)  != 0; br = (ctl & BR) != 0; jr  = (ctl & JR)  != 0;
        hr  = (ctl & HR)  != 0; rr = (ctl & RS) != 0;
        @(negedge clk);
        reset = rst; enable = en;
        bus.if_ready_i = rdy; bus.trap_req_i = tr; bus.trap_vec_i = tv;
        bus.branch_req_i = br; bus.branch_target_i = bt; bus.jump_req_i = jr;
        bus.jump_target_i = jt; bus.halt_req_i = hr; bus.resume_req_i = rr; bus.resume_pc_i = rp;
        #1;
        e_adv = 0; e_red = 0; e_flush = 0; e_halt = 0; e_pc = '0; e_src = SRC_NONE;
        if (!rst && en) begin
            if (m_boot) begin
                e_red = 1; e_pc = BOOT_PC;
            end else if (m_halted) begin
                e_halt = 1;
                if (rr) begin e_red = 1; e_pc = rp; end
            end else begin
                e_flush = (m_flush_left > 0);
                if (tr) begin
                    e_red = 1; e_pc = tv; e_src = 2'd3;
                end else if (!e_flush && br) begin
                    e_red = 1; e_pc = bt; e_src = 2'd2;
                end else if (!e_flush && jr) begin
                    e_red = 1; e_pc = jt; e_src = 2'd1;
                end
                e_adv = rdy & ~e_red;
            end
        end
        sat_big   = (m_cnt > 65535) ? 65535 : m_cnt;
        sat_small = (m_cnt > 7) ? 7 : m_cnt;
        check("advance",  64'(bus.pc_advance_o),   64'(e_adv));
        check("redirect", 64'(bus.pc_redirect_o),  64'(e_red));
        check("pc",       64'(bus.redirect_pc_o),  64'(e_pc));
        check("src",      64'(bus.redirect_src_o), 64'(e_src));
        check("flush",    64'(bus.flush_o),        64'(e_flush));
        check("halted",   64'(bus.halted_o),       64'(e_halt));
        check("cnt",      64'(bus.redirect_cnt_o), 64'(sat_big));
        check("cnt_sat",  64'(bus_s.redirect_cnt_o), 64'(sat_small));
        @(posedge clk);
        if (rst) begin
            m_boot = 1; m_halted = 0; m_pend = 0; m_flush_left = 0; m_cnt = 0;
        end else if (en) begin
            if (m_boot) begin
                m_boot = 0;
            end else if (m_halted) begin
                if (rr) begin
                    m_halted = 0; m_pend = 0; m_flush_left = FC; m_cnt++;
                end
            end else begin
                if (e_red) begin
                    m_cnt++; m_flush_left = FC;
                end else if (m_pend) begin
                    m_halted = 1; m_flush_left = 0;
                end else if (m_flush_left > 0) begin
                    m_flush_left--;
                end
                if (hr) m_pend = 1;
            end
        end
    endtask

    task automatic idle(input int ctl, input int n);
        for (int i = 0; i < n; i++) cyc(ctl, '0, '0, '0, '0);
    endtask

    initial begin
        int hold_halt;
        int ctl;
        n_chk = 0; n_pass = 0;
        m_boot = 1; m_halted = 0; m_pend = 0; m_flush_left = 0; m_cnt = 0;
        reset = 1'b1; enable = 1'b0;
        bus.if_ready_i = 0; bus.trap_req_i = 0; bus.trap_vec_i = '0;
        bus.branch_req_i = 0; bus.branch_target_i = '0; bus.jump_req_i = 0;
        bus.jump_target_i = '0; bus.halt_req_i = 0; bus.resume_req_i = 0; bus.resume_pc_i = '0;
        repeat (2) @(posedge clk);

        // Reset state, boot redirect, then steady advance.
        idle(RST | EN | RDY, 2);
        idle(EN | RDY, 4);

        // Simultaneous trap/branch/jump: trap wins, 2-cycle squash.
        cyc(EN | RDY | TR | BR | JR, 32'h100, 32'h200, 32'h300, '0);
        idle(EN | RDY, 3);

        // Branch, jump ignored during squash, trap in second squash cycle reloads it.
        cyc(EN | RDY | BR, '0, 32'h400, '0, '0);
        cyc(EN | RDY | JR, '0, '0, 32'h500, '0);
        cyc(EN | RDY | TR, 32'h600, '0, '0, '0);
        idle(EN | RDY, 3);

        // Halt alongside a jump: jump taken, halt follows; resume to 0x800.
        cyc(EN | RDY | HR | JR, '0, '0, 32'h700, '0);
        idle(EN | RDY | HR, 3);
        cyc(EN | RDY | HR | RS, '0, '0, '0, 32'h800);
        idle(EN | RDY, 4);

        // Enable dropped for 5 cycles mid-squash.
        cyc(EN | RDY | BR, '0, 32'h900, '0, '0);
        idle(EN | RDY, 1);
        idle(RDY | TR, 5);
        idle(EN | RDY, 3);

        // Reset mid-squash and while halted.
        cyc(EN | RDY | JR, '0, '0, 32'hA00, '0);
        idle(RST | EN | RDY, 1);
        idle(EN | RDY, 2);
        idle(EN | HR, 4);
        idle(RST | EN, 1);
        idle(EN | RDY, 2);

        // Random traffic.
        hold_halt = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) hold_halt = ~hold_halt & 1;
            ctl = 0;
            if ($urandom_range(199) == 0) ctl |= RST;
            if ($urandom_range(9) != 0)   ctl |= EN;
            if ($urandom_range(3) != 0)   ctl |= RDY;
            if ($urandom_range(7) == 0)   ctl |= TR;
            if ($urandom_range(4) == 0)   ctl |= BR;
            if ($urandom_range(4) == 0)   ctl |= JR;
            if (hold_halt != 0)           ctl |= HR;
            if ($urandom_range(3) == 0)   ctl |= RS;
            cyc(ctl, $urandom & ~32'h3, $urandom & ~32'h3, $urandom & ~32'h3, $urandom & ~32'h3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
